fp_div_seq: RTL and testbench

// Sequential IEEE-754 single-precision divider, z = a / b; the inverse companion of fp_mult.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_div_seq_round_div.sv | 83 ++++++++
 rtl/fp_div_seq.sv | 207 ++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the fp_* arithmetic blocks.
// Holds the rounding-mode encoding, status bit positions and IEEE-754 constants.
package fp_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } rnd_t;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;
    localparam int ST_DIV0    = 6;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] MAXNORM = 32'h7F7F_FFFF;
    localparam logic [31:0] MINNORM = 32'h0080_0000;
    localparam logic [31:0] INF     = 32'h7F80_0000;

    function automatic logic exp_all_ones(input logic [31:0] x);
        return &x[30:23];
    endfunction

endpackage

// File: rtl/fp_div_seq_round_div.sv
// Rounding and range check for the divider: normalised 24-bit mantissa plus
// guard/sticky in, packed single-precision result and status bits out.
module round_div
    import fp_pkg::*;
(
    input  logic               [23:0] mant,
    input  logic                      guard,
    input  logic                      sticky,
    input  logic                      sign,
    input  logic               [2:0]  rnd,
    input  logic signed        [9:0]  e,
    output logic               [31:0] z,
    output logic               [7:0]  status
);

    logic               inexact;
    logic               inc;
    logic        [24:0] sum;
    logic        [23:0] mant_r;
    logic signed [9:0]  e_r;
    logic               ovf_to_inf;
    logic               unf_to_min;

    always_comb begin
        inexact = guard | sticky;
        case (rnd)
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = inexact & ~sign;
            IEEE_ninf: inc = inexact & sign;
            near_up:   inc = guard & (~sign | sticky);
            away_zero: inc = inexact;
            default:   inc = guard & (sticky | mant[0]);
        endcase

        sum = {1'b0, mant} + {24'd0, inc};
        // A carry out of the mantissa leaves exactly 2^24, i.e. 1.0 at the next exponent.
        if (sum[24]) begin
            mant_r = sum[24:1];
            e_r    = e + 10'sd1;
        end else begin
            mant_r = sum[23:0];
            e_r    = e;
        end

        case (rnd)
            IEEE_zero: ovf_to_inf = 1'b0;
            IEEE_pinf: ovf_to_inf = ~sign;
            IEEE_ninf: ovf_to_inf = sign;
            default:   ovf_to_inf = 1'b1;
        endcase

        case (rnd)
            away_zero: unf_to_min = 1'b1;
            IEEE_pinf: unf_to_min = ~sign;
            IEEE_ninf: unf_to_min = sign;
            default:   unf_to_min = 1'b0;
        endcase

        status              = 8'd0;
        status[ST_INEXACT]  = inexact;
        z                   = {sign, e_r[7:0], mant_r[22:0]};

        if (e_r >= 10'sd255) begin
            status[ST_HUGE]    = 1'b1;
            status[ST_INEXACT] = 1'b1;
            if (ovf_to_inf) begin
                z = INF | {sign, 31'd0};
            end else begin
                z = MAXNORM | {sign, 31'd0};
            end
        end else if (e_r <= 10'sd0) begin
            status[ST_TINY]    = 1'b1;
            status[ST_INEXACT] = 1'b1;
            if (unf_to_min) begin
                z = MINNORM | {sign, 31'd0};
            end else begin
                z               = {sign, 31'd0};
                status[ST_ZERO] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: restoring mantissa division with
// ITER_PER_CYCLE (1 or 2) quotient bits per clock, then one rounding cycle.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [7:0]  status
);

    localparam int         NSTEP    = 26 / ITER_PER_CYCLE;
    localparam logic [4:0] CNT_INIT = 5'(NSTEP - 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t             state_reg, state_next;
    logic               sign_reg;
    logic        [2:0]  rnd_reg;
    logic signed [9:0]  exp_reg;
    logic        [23:0] mb_reg;
    logic        [25:0] rem_reg;
    logic        [25:0] q_reg;
    logic        [4:0]  cnt_reg;
    logic               out_valid_reg;
    logic        [31:0] z_reg;
    logic        [7:0]  status_reg;

    // Operand classification; exponent 0 (zero or denormal) counts as zero.
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic sign_in;
    logic spec_hit;
    logic [31:0] spec_z;
    logic [7:0]  spec_status;
    logic signed [9:0] exp_in;
    logic accept;

    assign a_nan   = exp_all_ones(a) & (|a[22:0]);
    assign b_nan   = exp_all_ones(b) & (|b[22:0]);
    assign a_inf   = exp_all_ones(a) & ~(|a[22:0]);
    assign b_inf   = exp_all_ones(b) & ~(|b[22:0]);
    assign a_zero  = (a[30:23] == 8'd0);
    assign b_zero  = (b[30:23] == 8'd0);
    assign sign_in = a[31] ^ b[31];
    assign exp_in  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;

    always_comb begin
        spec_hit    = 1'b1;
        spec_z      = 32'd0;
        spec_status = 8'd0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_z              = QNAN;
            spec_status[ST_NAN] = 1'b1;
        end else if (a_inf) begin
            spec_z              = INF | {sign_in, 31'd0};
            spec_status[ST_INF] = 1'b1;
        end else if (b_zero) begin
            spec_z               = INF | {sign_in, 31'd0};
            spec_status[ST_INF]  = 1'b1;
            spec_status[ST_DIV0] = 1'b1;
        end else if (a_zero | b_inf) begin
            spec_z               = {sign_in, 31'd0};
            spec_status[ST_ZERO] = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Unrolled restoring steps: compare, conditionally subtract, shift left.
    logic [25:0]               r_chain [0:ITER_PER_CYCLE];
    logic [ITER_PER_CYCLE-1:0] q_bits;
    logic [25:0]               q_next;

    assign r_chain[0] = rem_reg;

    generate
        for (genvar gi = 0; gi < ITER_PER_CYCLE; gi++) begin : g_step
            logic        ge;
            logic [25:0] diff;
            assign ge   = (r_chain[gi] >= {2'b00, mb_reg});
            assign diff = r_chain[gi] - {2'b00, mb_reg};
            assign q_bits[ITER_PER_CYCLE-1-gi] = ge;
            assign r_chain[gi+1] = ge ? {diff[24:0], 1'b0} : {r_chain[gi][24:0], 1'b0};
        end
    endgenerate

    assign q_next = {q_reg[25-ITER_PER_CYCLE:0], q_bits};

    logic        [23:0] rd_mant;
    logic               rd_guard;
    logic               rd_sticky;
    logic signed [9:0]  rd_e;
    logic        [31:0] rd_z;
    logic        [7:0]  rd_status;

    always_comb begin
        if (q_reg[25]) begin
            rd_mant   = q_reg[25:2];
            rd_guard  = q_reg[1];
            rd_sticky = q_reg[0] | (|rem_reg);
            rd_e      = exp_reg;
        end else begin
            rd_mant   = q_reg[24:1];
            rd_guard  = q_reg[0];
            rd_sticky = |rem_reg;
            rd_e      = exp_reg - 10'sd1;
        end
    end

    round_div u_round_div (
        .mant   (rd_mant),
        .guard  (rd_guard),
        .sticky (rd_sticky),
        .sign   (sign_reg),
        .rnd    (rnd_reg),
        .e      (rd_e),
        .z      (rd_z),
        .status (rd_status)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = spec_hit ? DONE : DIVIDE;
            DIVIDE:  if (cnt_reg == 5'd0) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_valid_reg && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        accept    = in_valid & in_ready;
        out_valid = out_valid_reg;
        z         = z_reg;
        status    = status_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg      <= 1'b0;
            rnd_reg       <= 3'd0;
            exp_reg       <= 10'sd0;
            mb_reg        <= 24'd0;
            rem_reg       <= 26'd0;
            q_reg         <= 26'd0;
            cnt_reg       <= 5'd0;
            out_valid_reg <= 1'b0;
            z_reg         <= 32'd0;
            status_reg    <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sign_reg <= sign_in;
                        rnd_reg  <= rnd;
                        exp_reg  <= exp_in;
                        mb_reg   <= {1'b1, b[22:0]};
                        rem_reg  <= {3'b001, a[22:0]};
                        q_reg    <= 26'd0;
                        cnt_reg  <= CNT_INIT;
                        if (spec_hit) begin
                            z_reg      <= spec_z;
                            status_reg <= spec_status;
                        end
                    end
                end
                DIVIDE: begin
                    rem_reg <= r_chain[ITER_PER_CYCLE];
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg - 5'd1;
                end
                ROUND: begin
                    z_reg      <= rd_z;
                    status_reg <= rd_status;
                end
                DONE: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq (ITER_PER_CYCLE=1): results, status,
// latency, output hold under backpressure and asynchronous reset.
module tb_fp_div_seq;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [2:0]  rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [7:0]  status;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.ITER_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .status    (status)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one operation and wait (bounded) for out_valid; inputs are scrambled after accept.
    task automatic do_op(input logic [31:0] aa, input logic [31:0] bb, input logic [2:0] rr,
                         output logic [31:0] zz, output logic [7:0] st, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check_val("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        a = aa; b = bb; rnd = rr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; rnd = 3'd1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        zz = z; st = status;
        $display("op a=%h b=%h rnd=%0d -> z=%h status=%h latency=%0d", aa, bb, rr, zz, st, lat);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check_val("in_ready_after", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [2:0] rr, input logic [31:0] ez, input logic [7:0] est,
                       input int elat);
        logic [31:0] zz;
        logic [7:0]  st;
        int          lat;
        do_op(aa, bb, rr, zz, st, lat);
        check_val({tag, "_z"}, zz, ez);
        check_val({tag, "_status"}, {24'd0, st}, {24'd0, est});
        check_val({tag, "_latency"}, lat, elat);
        finish_op();
    endtask

    initial begin
        logic [31:0] zz;
        logic [7:0]  st;
        int          lat;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; rnd = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_z", z, 32'd0);
        check_val("rst_status", {24'd0, status}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run("six_by_two",   32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 8'h00, 28);
        run("third_near",   32'h3F80_0000, 32'h4040_0000, 3'd0, 32'h3EAA_AAAB, 8'h20, 28);
        run("third_zero",   32'h3F80_0000, 32'h4040_0000, 3'd1, 32'h3EAA_AAAA, 8'h20, 28);
        run("div_by_zero",  32'h3F80_0000, 32'h0000_0000, 3'd0, 32'h7F80_0000, 8'h42, 1);
        run("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 8'h04, 1);
        run("ovf_near",     32'h7F7F_FFFF, 32'h3F00_0000, 3'd0, 32'h7F80_0000, 8'h30, 28);
        run("ovf_zero",     32'h7F7F_FFFF, 32'h3F00_0000, 3'd1, 32'h7F7F_FFFF, 8'h30, 28);
        run("unf_near",     32'h0080_0000, 32'h4B00_0000, 3'd0, 32'h0000_0000, 8'h29, 28);
        run("unf_away",     32'h0080_0000, 32'h4B00_0000, 3'd5, 32'h0080_0000, 8'h28, 28);
        run("neg_third_ninf", 32'hBF80_0000, 32'h4040_0000, 3'd3, 32'hBEAA_AAAB, 8'h20, 28);
        run("inf_by_fin",   32'hFF80_0000, 32'h4000_0000, 3'd0, 32'hFF80_0000, 8'h02, 1);
        run("fin_by_inf",   32'h4000_0000, 32'hFF80_0000, 3'd0, 32'h8000_0000, 8'h01, 1);
        run("illegal_rnd",  32'h3F80_0000, 32'h4040_0000, 3'd7, 32'h3EAA_AAAB, 8'h20, 28);

        // Backpressure: result must stay put and no new operand may be taken.
        do_op(32'h3F80_0000, 32'h4040_0000, 3'd0, zz, st, lat);
        a = 32'h4000_0000; b = 32'h3F80_0000; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("hold_z", z, 32'h3EAA_AAAB);
            check_val("hold_status", {24'd0, status}, 32'h20);
            check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        finish_op();

        // Reset while a result is being presented.
        do_op(32'h3F80_0000, 32'h0000_0000, 3'd0, zz, st, lat);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("async_rst_z", z, 32'd0);
        check_val("async_rst_status", {24'd0, status}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of DIVIDE, then a fresh operation must still be correct.
        a = 32'h40C0_0000; b = 32'h4000_0000; rnd = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("middiv_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("middiv_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        run("after_reset", 32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 8'h00, 28);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
